serial_tc_receiver: RTL and testbench
=====================================

# serial_tc_receiver

Bit-serial receiver for the two's-complement serial link. It samples an LSB-first serial stream produced by the serial two's-complementer and reassembles each W-bit frame into a parallel word. It also serially re-complements the stream (pass bits up to and including the first 1, invert every later bit) to recover the original operand. It sits at the far end of the serial datapath and hands parallel words plus a one-cycle valid pulse to downstream logic.

## Interface
Parameters:
- W, 8, frame length in bits; legal range W >= 2.

Ports:
- t_clk  in  1  system clock; all logic on rising edge.
- r_n  in  1  reset; asynchronous assert, active-low.
- s_in  in  1  serial data bit, LSB of frame first.
- s_vld  in  1  s_in carries a bit this cycle.
- s_sof  in  1  start of frame; qualified by s_vld and marks bit 0.
- p_raw  out  W  received word exactly as sent.
- p_out  out  W  recovered word, equal to the two's complement of p_raw modulo 2^W.
- p_vld  out  1  one-cycle pulse; p_raw, p_out and p_min are updated on this cycle.
- p_min  out  1  p_raw == 1 followed by W-1 zeros (most-negative value, which is its own complement).
- frm_err  out  1  one-cycle pulse on a framing violation.

## Operation
- States: IDLE, SHIFT. Internal registers:
  - cnt, $clog2(W) bits, counting bits received;
  - seen_one, a flag set once a 1 has been received in the frame;
  - sh_raw and sh_out, W-bit shift registers that fill from the MSB: sh <= {bit, sh[W-1:1]}.
- Accepted bit b, with recovered bit rb = seen_one ? ~b : b:
  - b shifts into sh_raw and rb shifts into sh_out;
  - seen_one <= seen_one | b;
  - cnt increments.
- IDLE behaviour:
  - s_vld & s_sof: accept the bit as bit 0 with seen_one treated as 0, then go to SHIFT with cnt = 1.
  - s_vld & !s_sof: drop the bit and pulse frm_err.
- SHIFT behaviour:
  - s_vld & !s_sof: accept the bit.
  - When the accepted bit is bit W-1: register {bit, sh_raw[W-1:1]} into p_raw and the matching value into p_out, compute p_min, pulse p_vld next cycle, and go to IDLE.
- SHIFT with s_vld & s_sof before bit W-1: pulse frm_err, discard the partial frame, and restart with this bit as bit 0 (cnt = 1, seen_one = b). The state stays SHIFT.
- s_vld low: no state change. Gaps of any length are legal both inside and between frames.
- p_raw, p_out and p_min hold their values between p_vld pulses.
- The arithmetic is modulo 2^W:
  - 0 maps to 0;
  - 2^(W-1) maps to itself and sets p_min;
  - no overflow flag beyond p_min.

## Timing
- Reset (r_n low, async): state IDLE, cnt 0, seen_one 0, shift registers 0, p_raw 0, p_out 0, p_vld 0, p_min 0, frm_err 0. Reset is released synchronously to t_clk.
- Latency: p_vld is high in the cycle immediately after the edge that sampled bit W-1, so one t_clk of latency.
- Back-to-back frames: s_sof on the cycle right after bit W-1 is accepted in IDLE with no error. The p_vld for the old frame and the acceptance of the new bit 0 occur in the same cycle.
- s_sof at bit position W-1 exactly: this is a framing error. The frame is restarted, not completed.
- frm_err is registered. It is high for the cycle after the offending sample.
- Reset mid-frame: the partial frame is lost and no p_vld is produced. The first valid bit after reset must carry s_sof.
- s_sof with s_vld low is ignored.

## Test plan
- W=8. Send original 0x05, i.e. serial 0xFB with bits LSB-first 1,1,0,1,1,1,1,1 and s_sof on the first bit, s_vld continuously high. Required: p_vld for one cycle after the 8th bit, p_raw=0xFB, p_out=0x05, p_min=0.
- Send frame 0x00, then frame 0x80 back-to-back with no idle cycle. Required: two p_vld pulses 8 cycles apart with no frm_err. First pulse: p_raw=0x00, p_out=0x00, p_min=0. Second pulse: p_raw=0x80, p_out=0x80, p_min=1.
- Send serial 0x38 (original 0xC8) with s_vld deasserted for 3 cycles after bits 2 and 5. Required: p_out=0xC8 and p_raw=0x38, with p_vld one cycle after the last bit. Outputs stay unchanged during the gaps.
- Send 4 bits of a frame, then s_sof with a new frame 0xFF. Required: one frm_err pulse, no p_vld for the partial frame, then p_raw=0xFF and p_out=0x01.
- Send valid bits in IDLE without s_sof. Required: one frm_err pulse per bit, no state change, p_raw and p_out held.
- Assert r_n low after 5 bits of a frame. Required: all outputs 0 immediately and no p_vld. A following full frame 0xFE decodes as p_out=0x02.

Source files
------------

// File: rtl/serial_tc_receiver_if.sv
// +----------------------------------------------------------------------+
// | serial_tc_receiver_if : serial-in / parallel-out link bundle          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface serial_tc_receiver_if #(
  parameter int W = 8
);
  logic         s_in;
  logic         s_vld;
  logic         s_sof;
  logic [W-1:0] p_raw;
  logic [W-1:0] p_out;
  logic         p_vld;
  logic         p_min;
  logic         frm_err;

  modport master (
    output s_in, s_vld, s_sof,
    input  p_raw, p_out, p_vld, p_min, frm_err
  );

  modport slave (
    input  s_in, s_vld, s_sof,
    output p_raw, p_out, p_vld, p_min, frm_err
  );
endinterface

`default_nettype wire

// File: rtl/serial_tc_receiver.sv
// +----------------------------------------------------------------------+
// | serial_tc_receiver : LSB-first frame deserialiser with serial        |
// | two's-complement recovery of the original operand.                   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module serial_tc_receiver #(
  parameter int W = 8
) (
  input  wire logic             t_clk,
  input  wire logic             r_n,
  serial_tc_receiver_if.slave   bus
);

  localparam int                 c_cnt_w    = $clog2(W);
  localparam logic [c_cnt_w-1:0] c_last     = c_cnt_w'(W - 1);
  localparam logic [W-1:0]       c_min_word = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_cnt_w-1:0]   w_cnt_nxt;
  logic                 r_seen;
  logic                 w_seen_nxt;
  // Bit 0 of each shift register is shifted out before it is ever read, so it is not kept.
  logic [W-1:1]         r_sh_raw;
  logic [W-1:1]         w_sh_raw_nxt;
  logic [W-1:1]         r_sh_out;
  logic [W-1:1]         w_sh_out_nxt;
  logic [W-1:0]         r_p_raw;
  logic [W-1:0]         w_p_raw_nxt;
  logic [W-1:0]         r_p_out;
  logic [W-1:0]         w_p_out_nxt;
  logic                 r_p_min;
  logic                 w_p_min_nxt;
  logic                 r_p_vld;
  logic                 w_p_vld_nxt;
  logic                 r_frm_err;
  logic                 w_frm_err_nxt;

  logic                 w_accept;
  logic                 w_restart;
  logic                 w_last;
  logic                 w_seen_eff;
  logic                 w_rb;
  logic [W-1:0]         w_raw_word;
  logic [W-1:0]         w_out_word;

  always_ff @(posedge t_clk or negedge r_n) begin
    if (!r_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_seen    <= 1'b0;
      r_sh_raw  <= '0;
      r_sh_out  <= '0;
      r_p_raw   <= '0;
      r_p_out   <= '0;
      r_p_min   <= 1'b0;
      r_p_vld   <= 1'b0;
      r_frm_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_seen    <= w_seen_nxt;
      r_sh_raw  <= w_sh_raw_nxt;
      r_sh_out  <= w_sh_out_nxt;
      r_p_raw   <= w_p_raw_nxt;
      r_p_out   <= w_p_out_nxt;
      r_p_min   <= w_p_min_nxt;
      r_p_vld   <= w_p_vld_nxt;
      r_frm_err <= w_frm_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_seen_nxt    = r_seen;
    w_sh_raw_nxt  = r_sh_raw;
    w_sh_out_nxt  = r_sh_out;
    w_p_raw_nxt   = r_p_raw;
    w_p_out_nxt   = r_p_out;
    w_p_min_nxt   = r_p_min;
    w_p_vld_nxt   = 1'b0;
    w_frm_err_nxt = 1'b0;
    w_accept      = 1'b0;
    w_restart     = 1'b0;

    case (r_state)
      IDLE: begin
        if (bus.s_vld) begin
          if (bus.s_sof) begin
            w_accept    = 1'b1;
            w_restart   = 1'b1;
            w_state_nxt = SHIFT;
          end else begin
            w_frm_err_nxt = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (bus.s_vld) begin
          w_accept = 1'b1;
          // A new start-of-frame abandons the partial frame, even at the last bit slot.
          if (bus.s_sof) begin
            w_restart     = 1'b1;
            w_frm_err_nxt = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    w_seen_eff = w_restart ? 1'b0 : r_seen;
    w_rb       = w_seen_eff ? ~bus.s_in : bus.s_in;
    w_raw_word = {bus.s_in, r_sh_raw};
    w_out_word = {w_rb, r_sh_out};
    w_last     = (r_state == SHIFT) && !bus.s_sof && (r_cnt == c_last);

    if (w_accept) begin
      w_sh_raw_nxt = w_raw_word[W-1:1];
      w_sh_out_nxt = w_out_word[W-1:1];
      w_seen_nxt   = w_seen_eff | bus.s_in;
      w_cnt_nxt    = w_restart ? c_cnt_w'(1) : r_cnt + c_cnt_w'(1);
      if (w_last) begin
        w_p_raw_nxt = w_raw_word;
        w_p_out_nxt = w_out_word;
        w_p_min_nxt = (w_raw_word == c_min_word);
        w_p_vld_nxt = 1'b1;
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
        w_seen_nxt  = 1'b0;
      end
    end
  end

  assign bus.p_raw   = r_p_raw;
  assign bus.p_out   = r_p_out;
  assign bus.p_min   = r_p_min;
  assign bus.p_vld   = r_p_vld;
  assign bus.frm_err = r_frm_err;

endmodule

`default_nettype wire

// File: tb/tb_serial_tc_receiver.sv
// +----------------------------------------------------------------------+
// | tb_serial_tc_receiver : directed bench for serial_tc_receiver (W=8)  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_serial_tc_receiver;
  localparam int W = 8;

  logic t_clk = 1'b0;
  logic r_n   = 1'b0;
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   n_vld = 0;
  int   n_err = 0;

  always #5 t_clk = ~t_clk;

  serial_tc_receiver_if #(.W(W)) bus ();

  serial_tc_receiver #(.W(W)) dut (
    .t_clk (t_clk),
    .r_n   (r_n),
    .bus   (bus)
  );

  // Pulse tallies, sampled mid-cycle.
  always @(negedge t_clk) begin
    if (bus.p_vld === 1'b1)   n_vld++;
    if (bus.frm_err === 1'b1) n_err++;
  end

  task automatic drive(input logic b, input logic v, input logic s);
    @(negedge t_clk);
    bus.s_in  = b;
    bus.s_vld = v;
    bus.s_sof = s;
    @(posedge t_clk);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] d, input int n);
    for (int i = 0; i < n; i++) drive(d[i], 1'b1, i == 0);
  endtask

  task automatic test_reset;
    bus.s_in = 1'b0; bus.s_vld = 1'b0; bus.s_sof = 1'b0;
    r_n = 1'b0;
    repeat (2) @(posedge t_clk);
    #1;
    tests_run++;
    if ({bus.p_vld, bus.frm_err, bus.p_min, bus.p_raw, bus.p_out} !== 19'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got vld=%b err=%b min=%b raw=%h out=%h want all 0",
               bus.p_vld, bus.frm_err, bus.p_min, bus.p_raw, bus.p_out);
    end
    @(negedge t_clk);
    r_n = 1'b1;
  endtask

  task automatic test_basic;
    send_bits(8'hFB, 7);
    tests_run++;
    if (bus.p_vld !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_early_vld: got %b want 0", bus.p_vld);
    end
    drive(1'b1, 1'b1, 1'b0);
    tests_run++;
    if ({bus.p_vld, bus.p_min, bus.p_raw, bus.p_out} !== {1'b1, 1'b0, 8'hFB, 8'h05}) begin
      tests_failed++;
      $display("FAIL basic_word: got vld=%b min=%b raw=%h out=%h want 1 0 fb 05",
               bus.p_vld, bus.p_min, bus.p_raw, bus.p_out);
    end
    drive(1'b0, 1'b0, 1'b0);
    tests_run++;
    if ({bus.p_vld, bus.p_raw, bus.p_out} !== {1'b0, 8'hFB, 8'h05}) begin
      tests_failed++;
      $display("FAIL basic_pulse_hold: got vld=%b raw=%h out=%h want 0 fb 05",
               bus.p_vld, bus.p_raw, bus.p_out);
    end
  endtask

  task automatic test_back_to_back;
    int e0;
    e0 = n_err;
    send_bits(8'h00, 8);
    tests_run++;
    if ({bus.p_vld, bus.p_min, bus.p_raw, bus.p_out} !== {1'b1, 1'b0, 8'h00, 8'h00}) begin
      tests_failed++;
      $display("FAIL b2b_first: got vld=%b min=%b raw=%h out=%h want 1 0 00 00",
               bus.p_vld, bus.p_min, bus.p_raw, bus.p_out);
    end
    drive(1'b0, 1'b1, 1'b1);
    tests_run++;
    if ({bus.p_vld, bus.frm_err} !== 2'b00) begin
      tests_failed++;
      $display("FAIL b2b_sof_accept: got vld=%b err=%b want 0 0", bus.p_vld, bus.frm_err);
    end
    for (int i = 1; i < 8; i++) drive(i == 7, 1'b1, 1'b0);
    tests_run++;
    if ({bus.p_vld, bus.p_min, bus.p_raw, bus.p_out} !== {1'b1, 1'b1, 8'h80, 8'h80}) begin
      tests_failed++;
      $display("FAIL b2b_second: got vld=%b min=%b raw=%h out=%h want 1 1 80 80",
               bus.p_vld, bus.p_min, bus.p_raw, bus.p_out);
    end
    drive(1'b0, 1'b0, 1'b0);
    tests_run++;
    if (n_err !== e0) begin
      tests_failed++;
      $display("FAIL b2b_no_err: got %0d frm_err pulses want 0", n_err - e0);
    end
  endtask

  task automatic test_gaps;
    logic [7:0] d;
    d = 8'h38;
    for (int i = 0; i < 8; i++) begin
      drive(d[i], 1'b1, i == 0);
      if (i == 2 || i == 5) begin
        for (int g = 0; g < 3; g++) begin
          drive(1'b1, 1'b0, g == 1);
          tests_run++;
          if ({bus.p_vld, bus.frm_err, bus.p_raw, bus.p_out} !== {2'b00, 8'h80, 8'h80}) begin
            tests_failed++;
            $display("FAIL gap_hold[%0d.%0d]: got vld=%b err=%b raw=%h out=%h want 0 0 80 80",
                     i, g, bus.p_vld, bus.frm_err, bus.p_raw, bus.p_out);
          end
        end
      end
    end
    tests_run++;
    if ({bus.p_vld, bus.p_min, bus.p_raw, bus.p_out} !== {1'b1, 1'b0, 8'h38, 8'hC8}) begin
      tests_failed++;
      $display("FAIL gap_word: got vld=%b min=%b raw=%h out=%h want 1 0 38 c8",
               bus.p_vld, bus.p_min, bus.p_raw, bus.p_out);
    end
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_frame_restart;
    int v0;
    v0 = n_vld;
    send_bits(8'h05, 4);
    drive(1'b1, 1'b1, 1'b1);
    tests_run++;
    if ({bus.frm_err, bus.p_vld} !== 2'b10) begin
      tests_failed++;
      $display("FAIL restart_err: got err=%b vld=%b want 1 0", bus.frm_err, bus.p_vld);
    end
    drive(1'b1, 1'b1, 1'b0);
    tests_run++;
    if (bus.frm_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL restart_err_pulse: got %b want 0", bus.frm_err);
    end
    for (int i = 2; i < 8; i++) drive(1'b1, 1'b1, 1'b0);
    tests_run++;
    if ({bus.p_vld, bus.p_min, bus.p_raw, bus.p_out} !== {1'b1, 1'b0, 8'hFF, 8'h01}) begin
      tests_failed++;
      $display("FAIL restart_word: got vld=%b min=%b raw=%h out=%h want 1 0 ff 01",
               bus.p_vld, bus.p_min, bus.p_raw, bus.p_out);
    end
    drive(1'b0, 1'b0, 1'b0);
    tests_run++;
    if (n_vld !== v0 + 1) begin
      tests_failed++;
      $display("FAIL restart_vld_count: got %0d want 1", n_vld - v0);
    end
  endtask

  task automatic test_sof_at_last;
    int v0;
    int e0;
    v0 = n_vld;
    e0 = n_err;
    send_bits(8'h55, 7);
    drive(1'b1, 1'b1, 1'b1);
    tests_run++;
    if ({bus.frm_err, bus.p_vld} !== 2'b10) begin
      tests_failed++;
      $display("FAIL lastsof_err: got err=%b vld=%b want 1 0", bus.frm_err, bus.p_vld);
    end
    for (int i = 1; i < 8; i++) drive(1'b0, 1'b1, 1'b0);
    tests_run++;
    if ({bus.p_vld, bus.p_min, bus.p_raw, bus.p_out} !== {1'b1, 1'b0, 8'h01, 8'hFF}) begin
      tests_failed++;
      $display("FAIL lastsof_word: got vld=%b min=%b raw=%h out=%h want 1 0 01 ff",
               bus.p_vld, bus.p_min, bus.p_raw, bus.p_out);
    end
    drive(1'b0, 1'b0, 1'b0);
    tests_run++;
    if ({n_vld - v0, n_err - e0} !== {32'd1, 32'd1}) begin
      tests_failed++;
      $display("FAIL lastsof_counts: got vld=%0d err=%0d want 1 1", n_vld - v0, n_err - e0);
    end
  endtask

  task automatic test_idle_no_sof;
    int e0;
    e0 = n_err;
    for (int i = 0; i < 3; i++) begin
      drive(i[0], 1'b1, 1'b0);
      tests_run++;
      if ({bus.frm_err, bus.p_vld, bus.p_raw, bus.p_out} !== {2'b10, 8'h01, 8'hFF}) begin
        tests_failed++;
        $display("FAIL idle_bit[%0d]: got err=%b vld=%b raw=%h out=%h want 1 0 01 ff",
                 i, bus.frm_err, bus.p_vld, bus.p_raw, bus.p_out);
      end
    end
    drive(1'b0, 1'b0, 1'b0);
    tests_run++;
    if (n_err !== e0 + 3 || bus.frm_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_err_count: got pulses=%0d err=%b want 3 0", n_err - e0, bus.frm_err);
    end
  endtask

  task automatic test_reset_midframe;
    int v0;
    v0 = n_vld;
    send_bits(8'hAA, 5);
    @(negedge t_clk);
    bus.s_vld = 1'b0;
    bus.s_sof = 1'b0;
    #2;
    r_n = 1'b0;
    #1;
    tests_run++;
    if ({bus.p_vld, bus.frm_err, bus.p_min, bus.p_raw, bus.p_out} !== 19'h0) begin
      tests_failed++;
      $display("FAIL midreset_outputs: got vld=%b err=%b min=%b raw=%h out=%h want all 0",
               bus.p_vld, bus.frm_err, bus.p_min, bus.p_raw, bus.p_out);
    end
    @(negedge t_clk);
    r_n = 1'b1;
    send_bits(8'hFE, 8);
    tests_run++;
    if ({bus.p_vld, bus.p_min, bus.p_raw, bus.p_out} !== {1'b1, 1'b0, 8'hFE, 8'h02}) begin
      tests_failed++;
      $display("FAIL midreset_word: got vld=%b min=%b raw=%h out=%h want 1 0 fe 02",
               bus.p_vld, bus.p_min, bus.p_raw, bus.p_out);
    end
    drive(1'b0, 1'b0, 1'b0);
    tests_run++;
    if (n_vld !== v0 + 1) begin
      tests_failed++;
      $display("FAIL midreset_vld_count: got %0d want 1", n_vld - v0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_gaps();
    test_frame_restart();
    test_sof_at_last();
    test_idle_no_sof();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
